// File: rtl/buttondetector_pkg.sv
// Shared constants and helpers for the push-button AXI4-Lite peripheral.
package buttondetector_pkg;

   // Register byte offsets; only bits [3:2] are decoded
   localparam logic [3:0] ADDR_CTRL     = 4'h0;
   localparam logic [3:0] ADDR_DEBOUNCE = 4'h4;
   localparam logic [3:0] ADDR_STATUS   = 4'h8;
   localparam logic [3:0] ADDR_STATE    = 4'hC;

   localparam int unsigned CTRL_IRQ_EN_BIT = 31;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef enum logic [1:0] {
      StIdle,
      StHaveAw,
      StHaveW,
      StResp
   } wr_state_e;

   // Expand a 4-bit byte strobe into a 32-bit bit mask
   function automatic logic [31:0] strb_mask(input logic [3:0] strb);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) begin
         m[i*8 +: 8] = {8{strb[i]}};
      end
      return m;
   endfunction

   // Merge write data into an old value on the strobed byte lanes only
   function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
      logic [31:0] m;
      m = strb_mask(strb);
      return (old_val & ~m) | (wdata & m);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, saturating-free counter and stable level.
module btn_debounce
   import buttondetector_pkg::*;
#(
   parameter int unsigned DEBOUNCE_W = 20
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_btn,
   input  logic [DEBOUNCE_W-1:0] i_thresh,
   output logic                  o_level
);

   logic                  r_sync1;
   logic                  r_sync2;
   logic                  r_level;
   logic [DEBOUNCE_W-1:0] r_cnt;
   logic [DEBOUNCE_W-1:0] w_cnt_nxt;
   logic                  w_level_nxt;
   logic [DEBOUNCE_W:0]   w_cnt_inc;
   logic [DEBOUNCE_W:0]   w_thresh_eff;

   // Count while the synchronised input disagrees; flip once the count would reach threshold.
   // Comparing against the live threshold lets a lowered threshold take effect immediately.
   always_comb begin
      w_cnt_inc    = {1'b0, r_cnt} + (DEBOUNCE_W + 1)'(1);
      w_thresh_eff = (i_thresh == '0) ? (DEBOUNCE_W + 1)'(1) : {1'b0, i_thresh};
      w_cnt_nxt    = '0;
      w_level_nxt  = r_level;
      if (r_sync2 != r_level) begin
         if (w_cnt_inc >= w_thresh_eff) begin
            w_level_nxt = r_sync2;
         end else begin
            w_cnt_nxt = w_cnt_inc[DEBOUNCE_W-1:0];
         end
      end
   end

   // Synchroniser, counter and stable level registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_level <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         r_level <= w_level_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   assign o_level = r_level;

endmodule

// File: rtl/buttondetector_axil_slave.sv
// AXI4-Lite slave for the push-button peripheral: CTRL, DEBOUNCE, W1C STATUS, RO STATE, irq.
module buttondetector_axil_slave
   import buttondetector_pkg::*;
#(
   parameter int unsigned NUM_BUTTONS        = 4,
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
   parameter int unsigned DEBOUNCE_W         = 20,
   parameter int unsigned DEBOUNCE_RST       = 100000
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   input  logic [NUM_BUTTONS-1:0]          btn_in,
   output logic                            irq
);

   wr_state_e              r_wr_state;
   wr_state_e              w_wr_state_nxt;
   logic                   w_awready;
   logic                   w_wready;
   logic                   w_bvalid;
   logic                   w_commit;
   logic [1:0]             r_aw_sel;
   logic [31:0]            r_wdata;
   logic [3:0]             r_wstrb;
   logic [1:0]             w_wr_sel;
   logic [31:0]            w_wr_data;
   logic [3:0]             w_wr_strb;
   logic [NUM_BUTTONS-1:0] r_ctrl_en;
   logic                   r_irq_en;
   logic [DEBOUNCE_W-1:0]  r_debounce;
   logic [NUM_BUTTONS-1:0] r_status;
   logic [NUM_BUTTONS-1:0] r_level_d;
   logic                   r_irq;
   logic [NUM_BUTTONS-1:0] w_level;
   logic [NUM_BUTTONS-1:0] w_set;
   logic [NUM_BUTTONS-1:0] w_clr;
   logic [31:0]            w_ctrl_rd;
   logic [31:0]            w_deb_rd;
   logic [31:0]            w_status_rd;
   logic [31:0]            w_state_rd;
   logic [31:0]            w_ctrl_wr;
   logic [31:0]            w_deb_wr;
   logic [31:0]            w_clr_mask;
   logic [31:0]            w_rd_mux;
   logic                   r_rvalid;
   logic [31:0]            r_rdata;
   logic                   w_unused_ok;

   for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_W (DEBOUNCE_W)
      ) u_debounce (
         .i_clk    (ACLK),
         .i_rst    (ARESET),
         .i_btn    (btn_in[gi]),
         .i_thresh (r_debounce),
         .o_level  (w_level[gi])
      );
   end

   // Write FSM: collect AW and W in any order, commit on the second, then hold B.
   // Readies are forced low while reset is asserted so the bus sees an idle slave.
   always_comb begin
      w_wr_state_nxt = r_wr_state;
      w_awready      = 1'b0;
      w_wready       = 1'b0;
      w_bvalid       = 1'b0;
      w_commit       = 1'b0;
      unique case (r_wr_state)
         StIdle: begin
            w_awready = !ARESET;
            w_wready  = !ARESET;
            if (w_awready && S_AXI_AWVALID && S_AXI_WVALID) begin
               w_commit       = 1'b1;
               w_wr_state_nxt = StResp;
            end else if (w_awready && S_AXI_AWVALID) begin
               w_wr_state_nxt = StHaveAw;
            end else if (w_wready && S_AXI_WVALID) begin
               w_wr_state_nxt = StHaveW;
            end
         end
         StHaveAw: begin
            w_wready = !ARESET;
            if (w_wready && S_AXI_WVALID) begin
               w_commit       = 1'b1;
               w_wr_state_nxt = StResp;
            end
         end
         StHaveW: begin
            w_awready = !ARESET;
            if (w_awready && S_AXI_AWVALID) begin
               w_commit       = 1'b1;
               w_wr_state_nxt = StResp;
            end
         end
         StResp: begin
            w_bvalid = 1'b1;
            if (S_AXI_BREADY) begin
               w_wr_state_nxt = StIdle;
            end
         end
         default: w_wr_state_nxt = StIdle;
      endcase
   end

   // Write FSM state register and latch for whichever half of the pair arrives first
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_wr_state <= StIdle;
         r_aw_sel   <= '0;
         r_wdata    <= '0;
         r_wstrb    <= '0;
      end else begin
         r_wr_state <= w_wr_state_nxt;
         if (w_awready && S_AXI_AWVALID) begin
            r_aw_sel <= S_AXI_AWADDR[3:2];
         end
         if (w_wready && S_AXI_WVALID) begin
            r_wdata <= S_AXI_WDATA;
            r_wstrb <= S_AXI_WSTRB;
         end
      end
   end

   assign w_wr_sel  = (r_wr_state == StHaveAw) ? r_aw_sel : S_AXI_AWADDR[3:2];
   assign w_wr_data = (r_wr_state == StHaveW)  ? r_wdata  : S_AXI_WDATA;
   assign w_wr_strb = (r_wr_state == StHaveW)  ? r_wstrb  : S_AXI_WSTRB;

   // 32-bit register views, strobe-merged write values and press-event set/clear vectors
   always_comb begin
      w_ctrl_rd                   = '0;
      w_ctrl_rd[NUM_BUTTONS-1:0]  = r_ctrl_en;
      w_ctrl_rd[CTRL_IRQ_EN_BIT]  = r_irq_en;
      w_deb_rd                    = '0;
      w_deb_rd[DEBOUNCE_W-1:0]    = r_debounce;
      w_status_rd                 = '0;
      w_status_rd[NUM_BUTTONS-1:0] = r_status;
      w_state_rd                  = '0;
      w_state_rd[NUM_BUTTONS-1:0] = w_level;
      w_ctrl_wr                   = apply_wstrb(w_ctrl_rd, w_wr_data, w_wr_strb);
      w_deb_wr                    = apply_wstrb(w_deb_rd, w_wr_data, w_wr_strb);
      w_clr_mask                  = w_wr_data & strb_mask(w_wr_strb);
      w_clr                       = '0;
      if (w_commit && (w_wr_sel == ADDR_STATUS[3:2])) begin
         w_clr = w_clr_mask[NUM_BUTTONS-1:0];
      end
      w_set = w_level & ~r_level_d & r_ctrl_en;
   end

   // Register file, edge history and interrupt; a new press beats a same-cycle clear
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_ctrl_en  <= '0;
         r_irq_en   <= 1'b0;
         r_debounce <= DEBOUNCE_W'(DEBOUNCE_RST);
         r_status   <= '0;
         r_level_d  <= '0;
         r_irq      <= 1'b0;
      end else begin
         if (w_commit && (w_wr_sel == ADDR_CTRL[3:2])) begin
            r_ctrl_en <= w_ctrl_wr[NUM_BUTTONS-1:0];
            r_irq_en  <= w_ctrl_wr[CTRL_IRQ_EN_BIT];
         end
         if (w_commit && (w_wr_sel == ADDR_DEBOUNCE[3:2])) begin
            r_debounce <= w_deb_wr[DEBOUNCE_W-1:0];
         end
         r_status  <= (r_status & ~w_clr) | w_set;
         r_level_d <= w_level;
         r_irq     <= r_irq_en & (|r_status);
      end
   end

   // Read data select on the AR address
   always_comb begin
      w_rd_mux = '0;
      case (S_AXI_ARADDR[3:2])
         ADDR_CTRL[3:2]:     w_rd_mux = w_ctrl_rd;
         ADDR_DEBOUNCE[3:2]: w_rd_mux = w_deb_rd;
         ADDR_STATUS[3:2]:   w_rd_mux = w_status_rd;
         default:            w_rd_mux = w_state_rd;
      endcase
   end

   // Read channel: capture on AR handshake, hold until RREADY
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
      end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
         r_rvalid <= 1'b1;
         r_rdata  <= w_rd_mux;
      end else if (S_AXI_RREADY) begin
         r_rvalid <= 1'b0;
      end
   end

   assign S_AXI_AWREADY = w_awready;
   assign S_AXI_WREADY  = w_wready;
   assign S_AXI_BVALID  = w_bvalid;
   assign S_AXI_BRESP   = RESP_OKAY;
   assign S_AXI_ARREADY = !r_rvalid && !ARESET;
   assign S_AXI_RVALID  = r_rvalid;
   assign S_AXI_RDATA   = r_rdata;
   assign S_AXI_RRESP   = RESP_OKAY;
   assign irq           = r_irq;

   assign w_unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR,
                          w_ctrl_wr, w_deb_wr, w_clr_mask};

endmodule

// File: tb/tb_buttondetector_axil_slave.sv
// Directed and randomized checks of the push-button AXI4-Lite slave.
module tb_buttondetector_axil_slave;

   localparam int NB = 4;

   logic          ACLK = 1'b0;
   logic          ARESET;
   logic [3:0]    S_AXI_AWADDR;
   logic [2:0]    S_AXI_AWPROT;
   logic          S_AXI_AWVALID;
   logic          S_AXI_AWREADY;
   logic [31:0]   S_AXI_WDATA;
   logic [3:0]    S_AXI_WSTRB;
   logic          S_AXI_WVALID;
   logic          S_AXI_WREADY;
   logic [1:0]    S_AXI_BRESP;
   logic          S_AXI_BVALID;
   logic          S_AXI_BREADY;
   logic [3:0]    S_AXI_ARADDR;
   logic [2:0]    S_AXI_ARPROT;
   logic          S_AXI_ARVALID;
   logic          S_AXI_ARREADY;
   logic [31:0]   S_AXI_RDATA;
   logic [1:0]    S_AXI_RRESP;
   logic          S_AXI_RVALID;
   logic          S_AXI_RREADY;
   logic [NB-1:0] btn_in;
   logic          irq;

   int total = 0;
   int bad   = 0;

   always #5 ACLK = ~ACLK;

   buttondetector_axil_slave #(
      .NUM_BUTTONS        (NB),
      .C_S_AXI_DATA_WIDTH (32),
      .C_S_AXI_ADDR_WIDTH (4),
      .DEBOUNCE_W         (20),
      .DEBOUNCE_RST       (100000)
   ) dut (
      .ACLK          (ACLK),
      .ARESET        (ARESET),
      .S_AXI_AWADDR  (S_AXI_AWADDR),
      .S_AXI_AWPROT  (S_AXI_AWPROT),
      .S_AXI_AWVALID (S_AXI_AWVALID),
      .S_AXI_AWREADY (S_AXI_AWREADY),
      .S_AXI_WDATA   (S_AXI_WDATA),
      .S_AXI_WSTRB   (S_AXI_WSTRB),
      .S_AXI_WVALID  (S_AXI_WVALID),
      .S_AXI_WREADY  (S_AXI_WREADY),
      .S_AXI_BRESP   (S_AXI_BRESP),
      .S_AXI_BVALID  (S_AXI_BVALID),
      .S_AXI_BREADY  (S_AXI_BREADY),
      .S_AXI_ARADDR  (S_AXI_ARADDR),
      .S_AXI_ARPROT  (S_AXI_ARPROT),
      .S_AXI_ARVALID (S_AXI_ARVALID),
      .S_AXI_ARREADY (S_AXI_ARREADY),
      .S_AXI_RDATA   (S_AXI_RDATA),
      .S_AXI_RRESP   (S_AXI_RRESP),
      .S_AXI_RVALID  (S_AXI_RVALID),
      .S_AXI_RREADY  (S_AXI_RREADY),
      .btn_in        (btn_in),
      .irq           (irq)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges, leaving time 1 unit past the last one
   task automatic tick(input int n);
      repeat (n) @(posedge ACLK);
      #1;
   endtask

   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
      logic aw_done, w_done, aw_hs, w_hs, got;
      int   n;
      S_AXI_AWADDR  = addr;
      S_AXI_WDATA   = data;
      S_AXI_WSTRB   = strb;
      S_AXI_AWVALID = 1'b1;
      S_AXI_WVALID  = 1'b1;
      aw_done = 1'b0;
      w_done  = 1'b0;
      n = 0;
      while (!(aw_done && w_done) && n < 50) begin
         @(negedge ACLK);
         aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
         w_hs  = S_AXI_WVALID && S_AXI_WREADY;
         @(posedge ACLK);
         #1;
         if (aw_hs) begin
            aw_done = 1'b1;
            S_AXI_AWVALID = 1'b0;
         end
         if (w_hs) begin
            w_done = 1'b1;
            S_AXI_WVALID = 1'b0;
         end
         n++;
      end
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      chk("wr_aw_w_accepted", 32'(aw_done && w_done), 32'd1);
      S_AXI_BREADY = 1'b1;
      resp = 2'bxx;
      got  = 1'b0;
      n    = 0;
      while (!got && n < 50) begin
         @(negedge ACLK);
         if (S_AXI_BVALID) begin
            got  = 1'b1;
            resp = S_AXI_BRESP;
         end
         @(posedge ACLK);
         #1;
         n++;
      end
      S_AXI_BREADY = 1'b0;
      chk("wr_bvalid_seen", 32'(got), 32'd1);
   endtask

   task automatic axi_read(input logic [3:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
      logic hs, got;
      int   n;
      S_AXI_ARADDR  = addr;
      S_AXI_ARVALID = 1'b1;
      hs = 1'b0;
      n  = 0;
      while (!hs && n < 50) begin
         @(negedge ACLK);
         hs = S_AXI_ARREADY;
         @(posedge ACLK);
         #1;
         n++;
      end
      S_AXI_ARVALID = 1'b0;
      S_AXI_RREADY  = 1'b1;
      data = 32'hxxxx_xxxx;
      resp = 2'bxx;
      got  = 1'b0;
      n    = 0;
      while (!got && n < 50) begin
         @(negedge ACLK);
         if (S_AXI_RVALID) begin
            got  = 1'b1;
            data = S_AXI_RDATA;
            resp = S_AXI_RRESP;
         end
         @(posedge ACLK);
         #1;
         n++;
      end
      S_AXI_RREADY = 1'b0;
      chk("rd_rvalid_seen", 32'(got), 32'd1);
   endtask

   task automatic wr(input logic [3:0] addr, input logic [31:0] data);
      logic [1:0] resp;
      axi_write(addr, data, 4'hF, resp);
   endtask

   task automatic rd_chk(input string tag, input logic [3:0] addr, input logic [31:0] exp);
      logic [31:0] data;
      logic [1:0]  resp;
      axi_read(addr, data, resp);
      chk(tag, data, exp);
      chk({tag, "_rresp"}, 32'(resp), 32'd0);
   endtask

   // Press button 2 and read STATE with the AR handshake on the given edge after the press
   task automatic state_read_at(input int hs_edge, output logic [31:0] data);
      btn_in[2] = 1'b1;
      tick(hs_edge - 1);
      S_AXI_ARADDR  = 4'hC;
      S_AXI_ARVALID = 1'b1;
      tick(1);
      S_AXI_ARVALID = 1'b0;
      chk("state_rd_rvalid", 32'(S_AXI_RVALID), 32'd1);
      data = S_AXI_RDATA;
      S_AXI_RREADY = 1'b1;
      tick(1);
      S_AXI_RREADY = 1'b0;
      btn_in[2] = 1'b0;
      tick(20);
   endtask

   initial begin : main
      logic [31:0] m_ctrl, m_deb, data, wdata, exp_status;
      logic [3:0]  addr, strb;
      logic [1:0]  resp;
      int          d, eff, len, b;

      ARESET = 1'b1;
      S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
      S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
      S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
      btn_in = '0;
      tick(3);

      // Outputs held quiet during reset
      chk("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
      chk("rst_wready",  32'(S_AXI_WREADY),  32'd0);
      chk("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
      chk("rst_bvalid",  32'(S_AXI_BVALID),  32'd0);
      chk("rst_rvalid",  32'(S_AXI_RVALID),  32'd0);
      chk("rst_irq",     32'(irq),           32'd0);
      chk("rst_rdata",   S_AXI_RDATA,        32'd0);
      ARESET = 1'b0;
      tick(2);

      rd_chk("reset_ctrl",   4'h0, 32'h0000_0000);
      rd_chk("reset_deb",    4'h4, 32'h0001_86A0);
      rd_chk("reset_status", 4'h8, 32'h0000_0000);
      rd_chk("reset_state",  4'hC, 32'h0000_0000);

      // Basic write/readback
      axi_write(4'h0, 32'h8000_000F, 4'hF, resp);
      chk("ctrl_bresp", 32'(resp), 32'd0);
      rd_chk("ctrl_rb", 4'h0, 32'h8000_000F);
      wr(4'h4, 32'h0000_0005);
      rd_chk("deb_rb", 4'h4, 32'h0000_0005);
      axi_write(4'hC, 32'hFFFF_FFFF, 4'hF, resp);
      chk("state_wr_bresp", 32'(resp), 32'd0);
      rd_chk("state_ro", 4'hC, 32'h0000_0000);

      // AW arrives well before W; commit must wait for W
      S_AXI_AWADDR  = 4'h0;
      S_AXI_WDATA   = 32'h8000_0004;
      S_AXI_WSTRB   = 4'hF;
      S_AXI_AWVALID = 1'b1;
      @(negedge ACLK);
      chk("aw_first_awready", 32'(S_AXI_AWREADY), 32'd1);
      tick(1);
      S_AXI_AWVALID = 1'b0;
      chk("aw_latched_awready", 32'(S_AXI_AWREADY), 32'd0);
      chk("aw_latched_wready",  32'(S_AXI_WREADY),  32'd1);
      tick(2);
      rd_chk("ctrl_before_w", 4'h0, 32'h8000_000F);
      S_AXI_WVALID = 1'b1;
      tick(1);
      S_AXI_WVALID = 1'b0;
      chk("bvalid_after_w", 32'(S_AXI_BVALID), 32'd1);
      S_AXI_BREADY = 1'b1;
      tick(1);
      S_AXI_BREADY = 1'b0;
      chk("bvalid_dropped", 32'(S_AXI_BVALID), 32'd0);
      rd_chk("ctrl_after_w", 4'h0, 32'h8000_0004);

      // Press latency with DEBOUNCE=5: stable at +7, STATUS at +8, irq at +9
      btn_in[2] = 1'b1;
      tick(8);
      chk("irq_not_yet", 32'(irq), 32'd0);
      tick(1);
      chk("irq_asserted", 32'(irq), 32'd1);
      rd_chk("status_press", 4'h8, 32'h0000_0004);
      rd_chk("state_press",  4'hC, 32'h0000_0004);
      btn_in[2] = 1'b0;
      tick(15);
      chk("irq_held_after_release", 32'(irq), 32'd1);
      wr(4'h8, 32'h0000_0004);
      chk("irq_cleared", 32'(irq), 32'd0);
      rd_chk("status_cleared", 4'h8, 32'h0000_0000);

      // Stable level flips exactly on the 7th edge after the press
      state_read_at(7, data);
      chk("state_edge7_old", data, 32'h0000_0000);
      state_read_at(8, data);
      chk("state_edge8_new", data, 32'h0000_0004);
      wr(4'h8, 32'h0000_000F);

      // 4-cycle glitch is shorter than the threshold
      btn_in[1] = 1'b1;
      tick(4);
      btn_in[1] = 1'b0;
      tick(15);
      rd_chk("glitch_state", 4'hC, 32'h0000_0000);

      // Events disabled: press leaves STATUS at 0
      wr(4'h0, 32'h0000_0000);
      btn_in[2] = 1'b1;
      tick(12);
      btn_in[2] = 1'b0;
      tick(12);
      rd_chk("disabled_status", 4'h8, 32'h0000_0000);
      chk("disabled_irq", 32'(irq), 32'd0);

      // Collision: W1C of bits 3:2 lands in the cycle button 2 sets again
      wr(4'h0, 32'h8000_000C);
      btn_in = 4'b1100;
      tick(10);
      btn_in = 4'b0000;
      tick(12);
      rd_chk("pre_collision_status", 4'h8, 32'h0000_000C);
      btn_in[2] = 1'b1;
      tick(7);
      S_AXI_AWADDR  = 4'h8;
      S_AXI_WDATA   = 32'h0000_000C;
      S_AXI_WSTRB   = 4'hF;
      S_AXI_AWVALID = 1'b1;
      S_AXI_WVALID  = 1'b1;
      S_AXI_ARADDR  = 4'h8;
      S_AXI_ARVALID = 1'b1;
      tick(1);
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      S_AXI_ARVALID = 1'b0;
      chk("collision_bvalid", 32'(S_AXI_BVALID), 32'd1);
      chk("collision_rvalid", 32'(S_AXI_RVALID), 32'd1);
      chk("collision_read_preclear", S_AXI_RDATA, 32'h0000_000C);
      S_AXI_BREADY = 1'b1;
      S_AXI_RREADY = 1'b1;
      tick(1);
      S_AXI_BREADY = 1'b0;
      S_AXI_RREADY = 1'b0;
      rd_chk("collision_status", 4'h8, 32'h0000_0004);
      btn_in[2] = 1'b0;
      tick(12);
      wr(4'h8, 32'h0000_000F);

      // B backpressure blocks further writes
      S_AXI_AWADDR  = 4'h4;
      S_AXI_WDATA   = 32'h0000_0005;
      S_AXI_AWVALID = 1'b1;
      S_AXI_WVALID  = 1'b1;
      tick(1);
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      tick(10);
      chk("bp_bvalid",  32'(S_AXI_BVALID),  32'd1);
      chk("bp_awready", 32'(S_AXI_AWREADY), 32'd0);
      chk("bp_wready",  32'(S_AXI_WREADY),  32'd0);
      S_AXI_BREADY = 1'b1;
      tick(1);
      S_AXI_BREADY = 1'b0;
      chk("bp_bvalid_done",  32'(S_AXI_BVALID),  32'd0);
      chk("bp_awready_back", 32'(S_AXI_AWREADY), 32'd1);

      // Random strobed writes against a byte-lane model of CTRL/DEBOUNCE
      m_ctrl = 32'h8000_000C;
      m_deb  = 32'h0000_0005;
      for (int i = 0; i < 16; i++) begin
         addr  = ($urandom_range(0, 1) == 1) ? 4'h4 : 4'h0;
         addr  = addr | 4'($urandom_range(0, 3));
         wdata = $urandom;
         strb  = 4'($urandom_range(0, 15));
         axi_write(addr, wdata, strb, resp);
         chk("rand_bresp", 32'(resp), 32'd0);
         for (int k = 0; k < 4; k++) begin
            if (strb[k]) begin
               if (addr[2]) m_deb[k*8 +: 8] = wdata[k*8 +: 8];
               else         m_ctrl[k*8 +: 8] = wdata[k*8 +: 8];
            end
         end
         m_deb  = m_deb & 32'h000F_FFFF;
         m_ctrl = m_ctrl & 32'h8000_000F;
         rd_chk(addr[2] ? "rand_deb_rb" : "rand_ctrl_rb", addr, addr[2] ? m_deb : m_ctrl);
      end

      // Random pulses: a press registers iff it lasts at least max(DEBOUNCE,1) cycles
      wr(4'h0, 32'h8000_000F);
      for (int i = 0; i < 10; i++) begin
         d   = (i < 2) ? $urandom_range(2, 6) : $urandom_range(0, 6);
         eff = (d == 0) ? 1 : d;
         len = (i == 0) ? eff : (i == 1) ? eff - 1 : $urandom_range(1, 10);
         b   = $urandom_range(0, NB - 1);
         wr(4'h4, 32'(d));
         wr(4'h8, 32'h0000_000F);
         btn_in[b] = 1'b1;
         tick(len);
         btn_in[b] = 1'b0;
         tick(eff + 10);
         exp_status = (len >= eff) ? (32'd1 << b) : 32'd0;
         rd_chk("rand_pulse_status", 4'h8, exp_status);
         chk("rand_pulse_irq", 32'(irq), 32'(exp_status != 0));
         rd_chk("rand_pulse_state", 4'hC, 32'h0000_0000);
      end

      // Reset with a read response pending returns everything to reset values
      wr(4'h4, 32'h0000_0003);
      btn_in[0] = 1'b1;
      tick(10);
      btn_in[0] = 1'b0;
      tick(10);
      chk("irq_before_reset", 32'(irq), 32'd1);
      S_AXI_ARADDR  = 4'h0;
      S_AXI_ARVALID = 1'b1;
      tick(1);
      S_AXI_ARVALID = 1'b0;
      chk("pending_rvalid", 32'(S_AXI_RVALID), 32'd1);
      ARESET = 1'b1;
      tick(1);
      chk("reset_drops_rvalid", 32'(S_AXI_RVALID), 32'd0);
      chk("reset_drops_irq",    32'(irq),          32'd0);
      ARESET = 1'b0;
      tick(1);
      rd_chk("post_rst_ctrl",   4'h0, 32'h0000_0000);
      rd_chk("post_rst_deb",    4'h4, 32'h0001_86A0);
      rd_chk("post_rst_status", 4'h8, 32'h0000_0000);
      rd_chk("post_rst_state",  4'hC, 32'h0000_0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
